// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate L1 data cache for
// the MEM stage, with a miss-handling controller.
//
// Ports
//   clk_i, rst_i          clock (posedge), asynchronous active-low reset
//   cpu_read_i/_write_i   MemRead / MemWrite from EX/MEM (both high = write)
//   cpu_addr_i            byte address, word access only ([1:0] ignored)
//   cpu_data_i            store data
//   cpu_data_o            load data on read hit, otherwise 0
//   cpu_stall_o           access not complete, pipeline must hold
//   mem_enable_o          one-cycle request pulse to line memory
//   mem_write_o           1 = write-back, 0 = fetch (qualified by mem_enable_o)
//   mem_addr_o            line-aligned request address
//   mem_data_o            victim line for write-back
//   mem_data_i            fetched line
//   mem_ack_i             one-cycle completion pulse for the outstanding request
module dcache_ctrl #(
  parameter int unsigned NUM_LINES = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_read_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned LINE_W = 256;
  localparam int unsigned TAG_W  = 32 - 5 - IDX_W;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WB_REQ  = 3'd1;
  localparam logic [2:0] S_WB_WAIT = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  logic [TAG_W-1:0]     miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]     miss_idx_q, miss_idx_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]    mem_data_q, mem_data_d;

  logic [TAG_W-1:0]     a_tag;
  logic [IDX_W-1:0]     a_idx;
  logic [2:0]           a_word;
  logic                 req, hit, rd_op, idle, wr_hit, fill;
  logic [31:0]          hit_word;
  logic                 unused_addr_lsb;

  assign a_tag  = cpu_addr_i[31:5+IDX_W];
  assign a_idx  = cpu_addr_i[4+IDX_W:5];
  assign a_word = cpu_addr_i[4:2];
  assign unused_addr_lsb = ^cpu_addr_i[1:0];

  assign req   = cpu_read_i | cpu_write_i;
  assign rd_op = cpu_read_i & ~cpu_write_i;
  assign hit   = req & valid_q[a_idx] & (tag_q[a_idx] == a_tag);
  assign idle  = (state_q == S_IDLE);

  assign hit_word = data_q[a_idx][{a_word, 5'd0} +: 32];

  // Write hits only commit in IDLE; a write miss completes here too once the
  // refilled line turns the held access into a hit.
  assign wr_hit = idle & hit & cpu_write_i;
  assign fill   = (state_q == S_RD_WAIT) & mem_ack_i;

  assign cpu_stall_o  = req & ~(idle & hit);
  assign cpu_data_o   = (rd_op & hit) ? hit_word : '0;
  assign mem_enable_o = (state_q == S_WB_REQ) | (state_q == S_RD_REQ);
  assign mem_write_o  = (state_q == S_WB_REQ);
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

  always_comb begin
    state_d    = state_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    case (state_q)
      S_IDLE: begin
        if (req & ~hit) begin
          // Tag/index are captured here so the fill lands correctly even if
          // the request drops or changes while the miss is in flight.
          miss_tag_d = a_tag;
          miss_idx_d = a_idx;
          if (valid_q[a_idx] & dirty_q[a_idx]) begin
            state_d    = S_WB_REQ;
            mem_addr_d = {tag_q[a_idx], a_idx, 5'b0};
            mem_data_d = data_q[a_idx];
          end else begin
            state_d    = S_RD_REQ;
            mem_addr_d = {a_tag, a_idx, 5'b0};
          end
        end
      end
      S_WB_REQ:  state_d = S_WB_WAIT;
      S_WB_WAIT: begin
        if (mem_ack_i) begin
          state_d    = S_RD_REQ;
          mem_addr_d = {miss_tag_q, miss_idx_q, 5'b0};
        end
      end
      S_RD_REQ:  state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (mem_ack_i) begin
          state_d = S_IDLE;
        end
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      if (fill) begin
        valid_q[miss_idx_q] <= 1'b1;
        dirty_q[miss_idx_q] <= 1'b0;
      end else if (wr_hit) begin
        dirty_q[a_idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      tag_q[miss_idx_q]  <= miss_tag_q;
      data_q[miss_idx_q] <= mem_data_i;
    end else if (wr_hit) begin
      data_q[a_idx][{a_word, 5'd0} +: 32] <= cpu_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: a transaction-level cache/memory model
// predicts every output each cycle, plus directed scenarios with literal values.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         cpu_read_i = 1'b0;
  logic         cpu_write_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_data_i = '0;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;

  always #5 clk_i = ~clk_i;

  dcache_ctrl #(.NUM_LINES(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_read_i(cpu_read_i), .cpu_write_i(cpu_write_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } op_t;

  bit           m_valid [16];
  bit           m_dirty [16];
  logic [22:0]  m_tag   [16];
  logic [255:0] m_line  [16];
  logic [255:0] mem [logic [31:0]];
  op_t          ops [$];      // memory operations still owed by the current miss
  bit           issued;       // front op has had its request pulse
  logic [3:0]   miss_idx;
  logic [22:0]  miss_tag;
  logic [31:0]  exp_maddr = '0;
  logic [255:0] exp_mdata = '0;
  bit           last_exp_stall = 0;

  int           ack_cnt = 0;
  int           lat_lo = 1, lat_hi = 1;
  bit           stray_en = 0, stray_now = 0;
  logic         nxt_ack = 0;
  logic [255:0] nxt_data = '0;

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom();
    return l;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = rand_line();
    return mem[a];
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    ops.delete();
    issued = 0;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_tag[i]  = '0;
      m_line[i] = '0;
    end
    clear_model();
  end

  task automatic do_compare();
    logic        req, hit, e_stall, e_en, e_w;
    logic [3:0]  idx;
    logic [22:0] tg;
    logic [31:0] e_data;
    logic [255:0] ln;
    req = cpu_read_i | cpu_write_i;
    idx = cpu_addr_i[8:5];
    tg  = cpu_addr_i[31:9];
    e_en = 0;
    e_w  = 0;
    e_data = '0;
    if (!rst_i) begin
      clear_model();
      e_stall   = req;
      exp_maddr = '0;
      exp_mdata = '0;
    end else begin
      hit = req && m_valid[idx] && (m_tag[idx] == tg);
      e_stall = req && !(ops.size() == 0 && hit);
      if (cpu_read_i && !cpu_write_i && hit) begin
        ln = m_line[idx];
        e_data = ln[cpu_addr_i[4:2]*32 +: 32];
      end
      if (ops.size() > 0) begin
        e_en = !issued;
        e_w  = e_en && ops[0].wr;
        exp_maddr = ops[0].addr;
        if (ops[0].wr) exp_mdata = ops[0].data;
      end
    end
    last_exp_stall = e_stall;
    chk("stall", cpu_stall_o, e_stall);
    chk("cpu_data", cpu_data_o, e_data);
    chk("mem_enable", mem_enable_o, e_en);
    chk("mem_write", mem_write_o, e_w);
    chk("mem_addr", mem_addr_o, exp_maddr);
    chk("mem_data", mem_data_o, exp_mdata);
  endtask

  initial forever begin
    @(negedge clk_i);
    do_compare();
  end

  task automatic model_step();
    logic        req, hit;
    logic [3:0]  idx;
    logic [22:0] tg;
    logic [255:0] ln;
    op_t         op;
    req = cpu_read_i | cpu_write_i;
    idx = cpu_addr_i[8:5];
    tg  = cpu_addr_i[31:9];
    hit = req && m_valid[idx] && (m_tag[idx] == tg);
    if (ops.size() == 0) begin
      if (req && hit && cpu_write_i) begin
        ln = m_line[idx];
        ln[cpu_addr_i[4:2]*32 +: 32] = cpu_data_i;
        m_line[idx]  = ln;
        m_dirty[idx] = 1;
      end else if (req && !hit) begin
        miss_idx = idx;
        miss_tag = tg;
        if (m_valid[idx] && m_dirty[idx]) begin
          op.wr = 1; op.addr = {m_tag[idx], idx, 5'b0}; op.data = m_line[idx];
          ops.push_back(op);
        end
        op.wr = 0; op.addr = {tg, idx, 5'b0}; op.data = '0;
        ops.push_back(op);
        issued = 0;
      end
    end else if (!issued) begin
      issued  = 1;
      ack_cnt = $urandom_range(lat_hi, lat_lo);
    end else if (mem_ack_i) begin
      if (ops[0].wr) begin
        mem[ops[0].addr] = ops[0].data;
      end else begin
        m_line[miss_idx]  = mem_data_i;
        m_valid[miss_idx] = 1;
        m_dirty[miss_idx] = 0;
        m_tag[miss_idx]   = miss_tag;
      end
      void'(ops.pop_front());
      issued = 0;
    end
  endtask

  // Model update and memory responder; ack is driven 1 time unit after posedge.
  initial forever begin
    @(posedge clk_i);
    nxt_ack  = 0;
    nxt_data = rand_line();
    if (!rst_i) begin
      clear_model();
    end else begin
      model_step();
      if (ops.size() > 0 && issued) begin
        if (ack_cnt == 0) begin
          nxt_ack = 1;
          if (!ops[0].wr) nxt_data = mem_line(ops[0].addr);
        end else begin
          ack_cnt--;
        end
      end else if (stray_now || (stray_en && $urandom_range(0, 7) == 0)) begin
        nxt_ack = 1;
      end
      stray_now = 0;
    end
    #1;
    mem_ack_i  = nxt_ack;
    mem_data_i = nxt_data;
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
    #1;
  endtask

  task automatic set_acc(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    cpu_read_i  = rd;
    cpu_write_i = wr;
    cpu_addr_i  = a;
    cpu_data_i  = d;
  endtask

  task automatic wait_pulse(input string nm);
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      sample();
      if (mem_enable_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk(nm, mem_enable_o, 1);
  endtask

  task automatic settle(input string nm);
    bit ok = 0;
    for (int i = 0; i < 80; i++) begin
      if (!cpu_stall_o) begin
        ok = 1;
        break;
      end
      sample();
    end
    if (!ok) chk(nm, cpu_stall_o, 0);
  endtask

  initial begin
    logic [255:0] line40;
    logic [31:0]  a;
    int           r;

    line40 = rand_line();
    line40[2*32 +: 32] = 32'hDEADBEEF;
    mem[32'h40] = line40;

    // reset state
    repeat (3) @(posedge clk_i);
    sample();
    chk("rst_stall", cpu_stall_o, 0);
    chk("rst_enable", mem_enable_o, 0);
    chk("rst_maddr", mem_addr_o, 0);

    // 1: cold read miss, fill, then hit on word 2
    next_cycle();
    rst_i = 1;
    set_acc(1, 0, 32'h40, 0);
    sample();
    chk("t1_miss_stall", cpu_stall_o, 1);
    wait_pulse("t1_pulse_timeout");
    chk("t1_addr", mem_addr_o, 32'h40);
    chk("t1_write", mem_write_o, 0);
    settle("t1_fill_timeout");
    next_cycle();
    set_acc(1, 0, 32'h48, 0);
    sample();
    chk("t1_stall", cpu_stall_o, 0);
    chk("t1_data", cpu_data_o, 32'hDEADBEEF);

    // 2: write hit, read back
    next_cycle();
    set_acc(0, 1, 32'h40, 32'h12345678);
    sample();
    chk("t2_wr_stall", cpu_stall_o, 0);
    next_cycle();
    set_acc(1, 0, 32'h40, 0);
    sample();
    chk("t2_data", cpu_data_o, 32'h12345678);

    // 3: dirty conflict, write-back then fetch
    next_cycle();
    set_acc(1, 0, 32'h240, 0);
    wait_pulse("t3_wb_timeout");
    chk("t3_wb_write", mem_write_o, 1);
    chk("t3_wb_addr", mem_addr_o, 32'h40);
    chk("t3_wb_word", mem_data_o[31:0], 32'h12345678);
    wait_pulse("t3_rd_timeout");
    chk("t3_rd_write", mem_write_o, 0);
    chk("t3_rd_addr", mem_addr_o, 32'h240);
    settle("t3_fill_timeout");

    // 4: clean conflict, fetch only
    next_cycle();
    set_acc(1, 0, 32'h440, 0);
    wait_pulse("t4_timeout");
    chk("t4_write", mem_write_o, 0);
    chk("t4_addr", mem_addr_o, 32'h440);
    settle("t4_fill_timeout");

    // 5: write miss allocates, then eviction shows the stored word
    next_cycle();
    set_acc(0, 1, 32'h80, 32'hCAFEF00D);
    wait_pulse("t5_timeout");
    chk("t5_write", mem_write_o, 0);
    chk("t5_addr", mem_addr_o, 32'h80);
    settle("t5_fill_timeout");
    next_cycle();
    set_acc(1, 0, 32'h80, 0);
    sample();
    chk("t5_data", cpu_data_o, 32'hCAFEF00D);
    next_cycle();
    set_acc(1, 0, 32'h280, 0);
    wait_pulse("t5_wb_timeout");
    chk("t5_wb_write", mem_write_o, 1);
    chk("t5_wb_addr", mem_addr_o, 32'h80);
    chk("t5_wb_word", mem_data_o[31:0], 32'hCAFEF00D);
    settle("t5_evict_timeout");

    // 6: reset during RD_WAIT, stray ack afterwards, prior line now misses
    lat_lo = 4;
    lat_hi = 4;
    next_cycle();
    set_acc(1, 0, 32'h300, 0);
    wait_pulse("t6_timeout");
    @(posedge clk_i);
    #2;
    rst_i = 0;
    set_acc(1, 0, 32'h440, 0);
    #1;
    chk("t6_rst_stall", cpu_stall_o, 1);
    chk("t6_rst_enable", mem_enable_o, 0);
    chk("t6_rst_maddr", mem_addr_o, 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1;
    stray_now = 1;
    sample();
    chk("t6_remiss", cpu_stall_o, 1);
    settle("t6_fill_timeout");

    // randomized traffic over 4 indices x 4 tags to force conflicts
    lat_lo = 0;
    lat_hi = 3;
    stray_en = 1;
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      if (last_exp_stall && (cpu_read_i || cpu_write_i)) begin
        if ($urandom_range(0, 15) == 0) set_acc(0, 0, cpu_addr_i, 0);
      end else begin
        a = {21'd0, 2'($urandom_range(0, 3)), 2'b0, 2'($urandom_range(0, 3)),
             3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
        r = $urandom_range(0, 19);
        if (r < 4)       set_acc(0, 0, a, $urandom());
        else if (r < 12) set_acc(1, 0, a, $urandom());
        else if (r < 19) set_acc(0, 1, a, $urandom());
        else             set_acc(1, 1, a, $urandom());
      end
    end
    set_acc(0, 0, 0, 0);
    repeat (20) @(posedge clk_i);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1);
  end

endmodule
